// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: fetch / decode / execute / memory / write-back.
// Owns PC, IR and the A/B/R operand/result registers; drives the unified
// memory port, the register-file read/write ports and the ALU.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  rf_raddr0,
  output logic [3:0]  rf_raddr1,
  input  logic [31:0] rf_rdata0,
  input  logic [31:0] rf_rdata1,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_ip_0,
  output logic [31:0] alu_ip_1,
  input  logic [31:0] alu_op_0,
  input  logic        alu_change_pc,
  output logic [31:0] pc,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [2:0] OP_LW = 3'b000;

  state_e      state_q, state_d;
  // Low for the first cycle out of reset so mem_req rises one cycle after
  // rst_n deasserts and a stale mem_ready at that edge is ignored.
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] r_q, r_d;

  logic [2:0]  op;
  logic [3:0]  rd, rs1, rs2;
  logic [31:0] simm;
  logic [31:0] pc_plus4;

  assign op       = ir_q[31:29];
  assign rd       = ir_q[28:25];
  assign rs1      = ir_q[24:21];
  assign rs2      = ir_q[20:17];
  assign simm     = {{15{ir_q[16]}}, ir_q[16:0]};
  assign pc_plus4 = pc_q + 32'd4;

  // State register and run flag; reset forces FETCH with outputs idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Datapath registers: PC, IR, operands and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      r_q  <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= a_d;
      b_q  <= b_d;
      r_q  <= r_d;
    end
  end

  // Next-state and datapath update for each phase of the instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    case (state_q)
      S_FETCH: begin
        if (run_q && mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_rdata0;
        b_d     = rf_rdata1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op[2]) begin
          r_d     = alu_op_0;
          state_d = S_WB;
        end else if (op[1]) begin
          pc_d    = alu_change_pc ? (pc_q + (simm << 2)) : pc_plus4;
          state_d = S_FETCH;
        end else begin
          r_d     = a_q + simm;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_LW) begin
            r_d     = mem_rdata;
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_plus4;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = r_q;
    mem_wdata  = b_q;
    rf_we      = 1'b0;
    alu_opcode = '0;
    case (state_q)
      S_FETCH: begin
        mem_req  = run_q;
        mem_addr = pc_q;
      end
      S_EXEC:  alu_opcode = op;
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op != OP_LW);
      end
      S_WB:    rf_we = 1'b1;
      default: ;
    endcase
  end

  assign rf_raddr0 = rs1;
  assign rf_raddr1 = rs2;
  assign rf_waddr  = rd;
  assign rf_wdata  = r_q;
  assign alu_ip_0  = a_q;
  assign alu_ip_1  = b_q;
  assign pc        = pc_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a small ISA model predicts fetch,
// load/store and write-back events; a memory responder/monitor compares them.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_raddr0, rf_raddr1, rf_waddr;
  logic [31:0] rf_rdata0, rf_rdata1, rf_wdata;
  logic        rf_we;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_ip_0, alu_ip_1, alu_op_0;
  logic        alu_change_pc;
  logic [31:0] pc;
  logic [2:0]  state;

  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_opcode(alu_opcode), .alu_ip_0(alu_ip_0), .alu_ip_1(alu_ip_1),
    .alu_op_0(alu_op_0), .alu_change_pc(alu_change_pc),
    .pc(pc), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] regs [16];
  logic [31:0] mem [logic [31:0]];
  logic        hold_ready  = 1'b0;
  logic        force_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'b100:  return x + y;
      3'b101:  return x - y;
      3'b110:  return x & y;
      3'b111:  return x | y;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic int unsigned waits_for(input logic [31:0] a);
    if (a == 32'd24)     return 5;
    if (a == 32'h104)    return 3;
    return 0;
  endfunction

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [16:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  // Register file and ALU behavioural models.
  assign rf_rdata0     = regs[rf_raddr0];
  assign rf_rdata1     = regs[rf_raddr1];
  assign alu_op_0      = alu_f(alu_opcode, alu_ip_0, alu_ip_1);
  assign alu_change_pc = (alu_opcode == 3'b010) ? (alu_ip_0 == alu_ip_1) :
                         (alu_opcode == 3'b011) ? (alu_ip_0 <  alu_ip_1) : 1'b0;

  function automatic ev_t mk(input logic [7:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    return e;
  endfunction

  // ISA model: walk n instructions from pc0, pushing every expected event.
  // F events carry the expected cycle gap from the previous fetch handshake.
  task automatic build_expect(input logic [31:0] pc0, input int unsigned n);
    logic [31:0] p, ins, x, y, simm, addr, npc;
    logic [2:0]  op;
    int unsigned prev;
    p = pc0;
    prev = 0;
    for (int unsigned k = 0; k < n; k++) begin
      ins  = rd_mem(p);
      exp_q.push_back(mk("F", p, prev + waits_for(p)));
      op   = ins[31:29];
      x    = regs[ins[24:21]];
      y    = regs[ins[20:17]];
      simm = {{15{ins[16]}}, ins[16:0]};
      addr = x + simm;
      npc  = p + 32'd4;
      if (op[2]) begin
        exp_q.push_back(mk("W", {28'h0, ins[28:25]}, alu_f(op, x, y)));
        prev = 4;
      end else if (op[1]) begin
        if ((op == 3'b010) ? (x == y) : (x < y)) npc = p + {simm[29:0], 2'b00};
        prev = 3;
      end else if (op == 3'b000) begin
        exp_q.push_back(mk("L", addr, 32'h0));
        exp_q.push_back(mk("W", {28'h0, ins[28:25]}, rd_mem(addr)));
        prev = 5 + waits_for(addr);
      end else begin
        exp_q.push_back(mk("S", addr, y));
        prev = 4 + waits_for(addr);
      end
      p = npc;
    end
    exp_q.push_back(mk("F", p, prev + waits_for(p)));
  endtask

  int unsigned cyc = 0;
  int unsigned last_f = 0;
  logic        have_prev = 1'b0;

  task automatic note_event(input logic [7:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("extra_event", {24'h0, k}, 32'h0);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", {24'h0, k}, {24'h0, e.kind});
    chk("ev_addr", a, e.a);
    if (k == "F") begin
      chk("pc", pc, e.a);
      chk("fetch_we", {31'h0, mem_we}, 32'h0);
      if (have_prev) chk("fetch_gap", cyc - last_f, e.d);
      have_prev = 1'b1;
      last_f    = cyc;
    end else if (k != "L") begin
      chk("ev_data", d, e.d);
    end
  endtask

  // Memory responder (decides mem_ready at negedge) and monitor (samples 1
  // time unit before the following rising edge).
  initial begin : responder
    int unsigned wcnt;
    logic        in_wait;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic [2:0]  h_state;
    logic [7:0]  k;
    wcnt = 0;
    in_wait = 1'b0;
    h_addr = '0; h_wdata = '0; h_we = 1'b0; h_state = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (force_ready) begin
        mem_ready = 1'b1;
        mem_rdata = rd_mem(mem_addr);
      end else if (mem_req && !hold_ready && wcnt >= waits_for(mem_addr)) begin
        mem_ready = 1'b1;
        mem_rdata = mem_we ? 32'h0 : rd_mem(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
      end
      #4;
      cyc++;
      if (!rst_n) have_prev = 1'b0;
      if (mem_req && !mem_ready) begin
        if (in_wait) begin
          chk("hold_addr", mem_addr, h_addr);
          chk("hold_we", {31'h0, mem_we}, {31'h0, h_we});
          chk("hold_wdata", mem_wdata, h_wdata);
          chk("hold_state", {29'h0, state}, {29'h0, h_state});
        end
        if (state == 3'd0) chk("stall_aluop", {29'h0, alu_opcode}, 32'h0);
        in_wait = 1'b1;
        h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata; h_state = state;
        wcnt++;
      end else begin
        in_wait = 1'b0;
        wcnt = 0;
      end
      if (mem_req && mem_ready) begin
        k = (state == 3'd0) ? "F" : (mem_we ? "S" : "L");
        note_event(k, mem_addr, mem_wdata);
      end
      if (rf_we) note_event("W", {28'h0, rf_waddr}, rf_wdata);
    end
  end

  task automatic wait_empty(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 32'h0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req"},   {31'h0, mem_req},    32'h0);
    chk({tag, "_we"},    {31'h0, mem_we},     32'h0);
    chk({tag, "_rfwe"},  {31'h0, rf_we},      32'h0);
    chk({tag, "_aluop"}, {29'h0, alu_opcode}, 32'h0);
    chk({tag, "_state"}, {29'h0, state},      32'h0);
    chk({tag, "_pc"},    pc,                  32'h0);
  endtask

  initial begin : main
    int unsigned n;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[1]  = 32'd5;        regs[2] = 32'd7;
    regs[4]  = 32'h200;      regs[5] = 32'hDEAD_BEEF;
    regs[6]  = 32'd9;        regs[7] = 32'd9;
    regs[8]  = 32'hFFFF_FFFF; regs[9] = 32'd1;
    regs[11] = 32'h100;
    mem[32'd0]   = enc(3'b100, 4'd3,  4'd1,  4'd2, 17'd0);      // ADD r3=r1+r2
    mem[32'd4]   = enc(3'b001, 4'd0,  4'd4,  4'd5, 17'h1FFFC);  // SW [r4-4]=r5
    mem[32'd8]   = enc(3'b010, 4'd0,  4'd6,  4'd7, 17'd2);      // BEQ taken -> 16
    mem[32'd16]  = enc(3'b011, 4'd0,  4'd8,  4'd9, 17'd7);      // BLT not taken
    mem[32'd20]  = enc(3'b000, 4'd10, 4'd11, 4'd0, 17'd4);      // LW r10=[r11+4]
    mem[32'd24]  = enc(3'b101, 4'd12, 4'd1,  4'd2, 17'd0);      // SUB
    mem[32'd28]  = enc(3'b110, 4'd13, 4'd5,  4'd8, 17'd0);      // AND
    mem[32'd32]  = enc(3'b111, 4'd14, 4'd1,  4'd2, 17'd0);      // OR
    mem[32'd36]  = enc(3'b010, 4'd0,  4'd1,  4'd2, 17'd5);      // BEQ not taken
    mem[32'd40]  = enc(3'b010, 4'd0,  4'd6,  4'd7, 17'h1FFF6);  // BEQ taken -> 0
    mem[32'h104] = 32'h1234_5678;

    #12;
    check_idle("rst");
    @(negedge clk);
    build_expect(32'd0, 11);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'h0, mem_req}, 32'h0);

    wait_empty("drain_prog", 400);

    // Second SW is left waiting in MEM, then reset lands mid-access.
    hold_ready = 1'b1;
    n = 0;
    while (state != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mem", {29'h0, state}, 32'd3);
    repeat (2) @(negedge clk);
    chk("mem_we_sw", {31'h0, mem_we}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async");
    force_ready = 1'b1;
    hold_ready  = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk("F", 32'd0, 32'd0));
    rst_n = 1'b1;
    #1;
    chk("rel2_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk);
    #1;
    chk("late_ready_state", {29'h0, state}, 32'h0);
    chk("first_req", {31'h0, mem_req}, 32'h1);
    force_ready = 1'b0;
    wait_empty("drain_rst", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
